// File: rtl/id_ex_stage.sv
// ID->EX pipeline register for the RV32I core.
// Load-use hazard bubble, branch flush and a saturating stall counter.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [7:0]       id_ctrl,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic [3:0]       id_funct,
    input  logic             flush,
    output logic             ex_valid,
    output logic [7:0]       ex_ctrl,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [RA_W-1:0]  ex_rs1,
    output logic [RA_W-1:0]  ex_rs2,
    output logic [RA_W-1:0]  ex_rd,
    output logic [3:0]       ex_funct,
    output logic             stall,
    output logic [CNT_W-1:0] stall_count
);

    // Bit positions in {branch,memRead,memToReg,memWrite,ALUsrc,regWrite,ALUop}
    localparam int MEM_READ  = 6;
    localparam int MEM_WRITE = 4;
    localparam int ALU_SRC   = 3;

    logic uses_rs2;
    logic load_use;

    assign uses_rs2 = ~id_ctrl[ALU_SRC] | id_ctrl[MEM_WRITE];

    assign load_use = ex_valid & ex_ctrl[MEM_READ] & (ex_rd != '0) & id_valid &
                      ((ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2)));

    // A flushed dependent instruction dies anyway, so there is nothing to hold.
    assign stall = load_use & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else if (flush || load_use) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? id_ctrl : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_funct    <= '0;
        end else if (!flush && !load_use) begin
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_funct    <= id_funct;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: vector table, hand sequences
// and a randomized run against a behavioural reference model.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [7:0]  id_ctrl;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [3:0]  id_funct;
    logic        flush;

    logic        ex_valid, ex_valid2;
    logic [7:0]  ex_ctrl, ex_ctrl2;
    logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [31:0] ex_pc2, ex_rs1_data2, ex_rs2_data2, ex_imm2;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd, ex_rs12, ex_rs22, ex_rd2;
    logic [3:0]  ex_funct, ex_funct2;
    logic        stall, stall2;
    logic [15:0] stall_count;
    logic [1:0]  stall_count2;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct(id_funct), .flush(flush), .ex_valid(ex_valid),
        .ex_ctrl(ex_ctrl), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct(ex_funct), .stall(stall),
        .stall_count(stall_count)
    );

    id_ex_stage #(.CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_pc(id_pc), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_funct(id_funct), .flush(flush), .ex_valid(ex_valid2),
        .ex_ctrl(ex_ctrl2), .ex_pc(ex_pc2), .ex_rs1_data(ex_rs1_data2),
        .ex_rs2_data(ex_rs2_data2), .ex_imm(ex_imm2), .ex_rs1(ex_rs12),
        .ex_rs2(ex_rs22), .ex_rd(ex_rd2), .ex_funct(ex_funct2), .stall(stall2),
        .stall_count(stall_count2)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  ctrl;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] pc;
        logic        fl;
        logic        e_stall;
        logic        e_v;
        logic [7:0]  e_ctrl;
        logic [4:0]  e_rd;
        logic [31:0] e_pc;
        logic [15:0] e_cnt;
    } vec_t;

    localparam logic [7:0] R_OP  = 8'b00000110;
    localparam logic [7:0] LW_OP = 8'b01101100;
    localparam logic [7:0] SW_OP = 8'b00011000;
    localparam logic [7:0] AI_OP = 8'b00001100;

    task automatic drive(input logic v, input logic [7:0] c, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] d,
                         input logic [31:0] pc, input logic fl);
        id_valid    = v;
        id_ctrl     = c;
        id_rs1      = r1;
        id_rs2      = r2;
        id_rd       = d;
        id_pc       = pc;
        id_rs1_data = pc ^ 32'hA5A5_0000;
        id_rs2_data = pc ^ 32'h0000_5A5A;
        id_imm      = pc + 32'd7;
        id_funct    = pc[3:0];
        flush       = fl;
    endtask

    // Reference model state: contents of the EX slot and the counters
    logic        m_v;
    logic [7:0]  m_ctrl;
    logic [31:0] m_pc, m_d1, m_d2, m_imm;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [3:0]  m_funct;
    int          m_cnt, m_cnt2;

    function automatic logic model_hazard();
        logic reads_rs2;
        reads_rs2 = !id_ctrl[3] || id_ctrl[4];
        return m_v && m_ctrl[6] && (m_rd != 0) && id_valid &&
               ((m_rd == id_rs1) || (reads_rs2 && (m_rd == id_rs2)));
    endfunction

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1, R_OP,  1, 2, 3,  32'h40, 0, 0, 1, R_OP,  3,  32'h40, 0};
        tbl[1]  = '{1, LW_OP, 1, 0, 5,  32'h44, 0, 0, 1, LW_OP, 5,  32'h44, 0};
        tbl[2]  = '{1, R_OP,  5, 2, 6,  32'h48, 0, 1, 0, 8'h00, 5,  32'h44, 1};
        tbl[3]  = '{1, R_OP,  5, 2, 6,  32'h48, 0, 0, 1, R_OP,  6,  32'h48, 1};
        tbl[4]  = '{1, LW_OP, 2, 0, 0,  32'h4C, 0, 0, 1, LW_OP, 0,  32'h4C, 1};
        tbl[5]  = '{1, R_OP,  0, 0, 8,  32'h50, 0, 0, 1, R_OP,  8,  32'h50, 1};
        tbl[6]  = '{1, LW_OP, 1, 0, 7,  32'h54, 0, 0, 1, LW_OP, 7,  32'h54, 1};
        tbl[7]  = '{1, AI_OP, 1, 7, 9,  32'h58, 0, 0, 1, AI_OP, 9,  32'h58, 1};
        tbl[8]  = '{1, LW_OP, 1, 0, 7,  32'h5C, 0, 0, 1, LW_OP, 7,  32'h5C, 1};
        tbl[9]  = '{1, SW_OP, 1, 7, 10, 32'h60, 0, 1, 0, 8'h00, 7,  32'h5C, 2};
        tbl[10] = '{1, SW_OP, 1, 7, 10, 32'h60, 0, 0, 1, SW_OP, 10, 32'h60, 2};
        tbl[11] = '{1, LW_OP, 1, 0, 5,  32'h64, 0, 0, 1, LW_OP, 5,  32'h64, 2};
        tbl[12] = '{1, R_OP,  5, 2, 6,  32'h68, 1, 0, 0, 8'h00, 5,  32'h64, 2};
        tbl[13] = '{0, R_OP,  5, 2, 11, 32'h6C, 0, 0, 0, 8'h00, 11, 32'h6C, 2};

        drive(0, 8'h00, 0, 0, 0, 32'h0, 0);
        rst = 1'b1;
        #1;
        check("reset_valid", {31'b0, ex_valid}, 0);
        check("reset_cnt", {16'b0, stall_count}, 0);
        check("reset_stall", {31'b0, stall}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].ctrl, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                  tbl[i].pc, tbl[i].fl);
            #1;
            check($sformatf("vec%0d_stall", i), {31'b0, stall}, {31'b0, tbl[i].e_stall});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_valid", i), {31'b0, ex_valid}, {31'b0, tbl[i].e_v});
            check($sformatf("vec%0d_ctrl", i), {24'b0, ex_ctrl}, {24'b0, tbl[i].e_ctrl});
            check($sformatf("vec%0d_rd", i), {27'b0, ex_rd}, {27'b0, tbl[i].e_rd});
            check($sformatf("vec%0d_pc", i), ex_pc, tbl[i].e_pc);
            check($sformatf("vec%0d_cnt", i), {16'b0, stall_count}, {16'b0, tbl[i].e_cnt});
        end

        // Saturation: four more load-use events; narrow counter pins at 3
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, LW_OP, 1, 0, 5, 32'h100, 0);
            @(negedge clk);
            drive(1, R_OP, 5, 2, 6, 32'h104, 0);
            #1;
            check($sformatf("sat%0d_stall", k), {31'b0, stall}, 1);
            @(posedge clk);
        end
        #1;
        check("sat_cnt_narrow", {30'b0, stall_count2}, 3);
        check("sat_cnt_wide", {16'b0, stall_count}, 6);

        // Reset in the middle of a stall
        @(negedge clk);
        drive(1, LW_OP, 1, 0, 5, 32'h200, 0);
        @(negedge clk);
        drive(1, R_OP, 5, 2, 6, 32'h204, 0);
        #1;
        check("midrst_pre_stall", {31'b0, stall}, 1);
        rst = 1'b1;
        #1;
        check("midrst_stall", {31'b0, stall}, 0);
        check("midrst_valid", {31'b0, ex_valid}, 0);
        check("midrst_ctrl", {24'b0, ex_ctrl}, 0);
        check("midrst_rd", {27'b0, ex_rd}, 0);
        check("midrst_pc", ex_pc, 0);
        check("midrst_imm", ex_imm, 0);
        check("midrst_cnt", {16'b0, stall_count}, 0);
        check("midrst_cnt2", {30'b0, stall_count2}, 0);
        @(negedge clk);
        rst = 1'b0;

        m_v = 0; m_ctrl = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_funct = 0; m_cnt = 0; m_cnt2 = 0;

        for (int n = 0; n < 300; n++) begin
            logic hz;
            @(negedge clk);
            id_valid    = ($urandom_range(0, 7) != 0);
            id_ctrl     = 8'($urandom);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            id_rd       = 5'($urandom_range(0, 3));
            id_pc       = $urandom;
            id_rs1_data = $urandom;
            id_rs2_data = $urandom;
            id_imm      = $urandom;
            id_funct    = 4'($urandom);
            flush       = ($urandom_range(0, 7) == 0);
            #1;
            hz = model_hazard();
            check("rnd_stall", {31'b0, stall}, {31'b0, hz && !flush});
            if (flush || hz) begin
                m_v = 0;
                m_ctrl = 0;
                if (!flush) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                end
            end else begin
                m_v = id_valid;
                m_ctrl = id_valid ? id_ctrl : 8'h00;
                m_pc = id_pc; m_d1 = id_rs1_data; m_d2 = id_rs2_data;
                m_imm = id_imm; m_rs1 = id_rs1; m_rs2 = id_rs2;
                m_rd = id_rd; m_funct = id_funct;
            end
            @(posedge clk);
            #1;
            check("rnd_valid", {31'b0, ex_valid}, {31'b0, m_v});
            check("rnd_ctrl", {24'b0, ex_ctrl}, {24'b0, m_ctrl});
            check("rnd_pc", ex_pc, m_pc);
            check("rnd_d1", ex_rs1_data, m_d1);
            check("rnd_d2", ex_rs2_data, m_d2);
            check("rnd_imm", ex_imm, m_imm);
            check("rnd_regs", {17'b0, ex_rs1, ex_rs2, ex_rd}, {17'b0, m_rs1, m_rs2, m_rd});
            check("rnd_funct", {28'b0, ex_funct}, {28'b0, m_funct});
            check("rnd_cnt", {16'b0, stall_count}, m_cnt);
            check("rnd_cnt2", {30'b0, stall_count2}, m_cnt2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
